// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared definitions for the systolic matmul array: controller states, flush length, defaults.
package systolic_pkg;

  localparam int DEFAULT_N  = 4;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Buffer latency + skew + propagation to the far corner + one accumulate.
  function automatic int flush_len(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Command, operand-read, lane-valid and result-row signals of the systolic sequencing controller.
interface systolic_seq_ctrl_if
  import systolic_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int KW = 8,
    parameter int RW = (N > 1) ? $clog2(N) : 1
);
    // Result rows use valid/ready: a beat transfers on a cycle where out_valid and
    // out_ready are both 1; while out_ready is 0, out_valid and out_row hold.
    logic          start;
    logic [KW-1:0] k_len;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          pe_clr;
    logic          rd_en;
    logic [KW-1:0] rd_addr;
    logic [N-1:0]  lane_valid_w;
    logic [N-1:0]  lane_valid_n;
    logic          out_valid;
    logic [RW-1:0] out_row;
    logic [31:0]   perf_cycles;
    state_t        dbg_state;

    modport master (
        input  start, k_len, out_ready,
        output busy, done, pe_clr, rd_en, rd_addr, lane_valid_w, lane_valid_n,
               out_valid, out_row, perf_cycles, dbg_state
    );

    modport slave (
        output start, k_len, out_ready,
        input  busy, done, pe_clr, rd_en, rd_addr, lane_valid_w, lane_valid_n,
               out_valid, out_row, perf_cycles, dbg_state
    );
endinterface

// File: rtl/skew_valid_sr.sv
// N-stage shift register: tap i is the input delayed by 1+i cycles.
module skew_valid_sr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    output logic [N-1:0] taps
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < N; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Tile-job sequencer for the N x N output-stationary systolic array.
// Optional busy-cycle counter enabled by defining SYSCTRL_PERF_CNT_EN.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int KW = 8,
    parameter int RW = (N > 1) ? $clog2(N) : 1
) (
    input logic clk,
    input logic rst,
    systolic_seq_ctrl_if.master bus
);

    localparam int CW = $clog2(flush_len(N) + 1);

    state_t        state;
    logic [KW-1:0] k_reg;
    logic [CW-1:0] cnt;
    logic          pe_clr_q;
    logic          rd_en_q;
    logic [KW-1:0] rd_addr_q;
    logic          out_valid_q;
    logic [RW-1:0] out_row_q;
    logic          done_q;
    logic          busy;
    logic [N-1:0]  taps;

    assign busy = (state == S_CLEAR) || (state == S_FEED) ||
                  (state == S_FLUSH) || (state == S_DRAIN);

    // Outputs are registered: each transition loads the values for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            k_reg       <= '0;
            cnt         <= '0;
            pe_clr_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            pe_clr_q <= 1'b0;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        cnt <= '0;
                        if (bus.k_len != '0) begin
                            state    <= S_CLEAR;
                            k_reg    <= bus.k_len;
                            pe_clr_q <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state     <= S_FEED;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                end
                S_FEED: begin
                    if (rd_addr_q == k_reg - KW'(1)) begin
                        state <= S_FLUSH;
                        cnt   <= '0;
                    end else begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_q + KW'(1);
                    end
                end
                S_FLUSH: begin
                    if (cnt == CW'(flush_len(N) - 1)) begin
                        state       <= S_DRAIN;
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (out_row_q == RW'(N - 1)) begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            out_row_q <= out_row_q + RW'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // West rows and north columns share the same skew, so one register feeds both.
    skew_valid_sr #(.N(N)) u_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_en_q),
        .taps (taps)
    );

`ifdef SYSCTRL_PERF_CNT_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state == S_IDLE && bus.start) begin
            perf_q <= '0;
        end else if (busy && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end
    assign bus.perf_cycles = perf_q;
`else
    assign bus.perf_cycles = 32'd0;
`endif

    assign bus.busy         = busy;
    assign bus.done         = done_q;
    assign bus.pe_clr       = pe_clr_q;
    assign bus.rd_en        = rd_en_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.lane_valid_w = taps;
    assign bus.lane_valid_n = taps;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_row      = out_row_q;
    assign bus.dbg_state    = state;

endmodule
